// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for a 32-bit debug value.
// Free-running round-robin scan with one dead cycle at the start of every digit slot.
module seg7_scan_driver #(
  parameter int DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        half_sel,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit;
  logic [31:0]      shadow;
  logic             half_q;
  logic             blank_q;

  logic [4:0]       nib_base;
  logic [3:0]       nib;
  logic [6:0]       hex7;
  logic [3:0]       digit_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      digit   <= 2'd0;
      shadow  <= 32'd0;
      half_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      // Advance together with the prescaler wrap so the new slot opens on its dead cycle.
      if (&div_cnt) begin
        digit <= digit + 2'd1;
      end
      if (load) begin
        shadow <= data;
      end
      half_q  <= half_sel;
      blank_q <= blank;
    end
  end

  assign nib_base     = {half_q, digit, 2'b00};
  assign nib          = shadow[nib_base +: 4];
  assign digit_onehot = 4'b0001 << digit;

  always_comb begin
    hex7 = 7'h0E;
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  end

  always_comb begin
    an  = 4'b1111;
    seg = 8'hFF;
    if ((div_cnt != '0) && !blank_q) begin
      an  = ~digit_onehot;
      seg = {1'b1, hex7};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIV_W=2): stimulus pushes expected an/seg per cycle,
// a monitor pops and compares on every falling edge.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        load;
  logic        half_sel;
  logic        blank;
  logic [3:0]  an;
  logic [7:0]  seg;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    string      tag;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;

  seg7_scan_driver #(.DIV_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .load     (load),
    .half_sel (half_sel),
    .blank    (blank),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL %s t=%0d: an=%b seg=%h, expected an=%b seg=%h",
                 e.tag, e.t, an, seg, e.an, e.seg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic expect_out(input logic [3:0] a, input logic [7:0] s, input string tag);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.tag = tag;
    e.t   = t;
    exp_q.push_back(e);
    $display("cycle t=%0d %s: expect an=%b seg=%h", t, tag, a, s);
  endtask

  // Advance to t_end; segs packs the four hand-decoded digit patterns {d3,d2,d1,d0}.
  // Cycles in [blo,bhi] are expected blanked.
  task automatic scan_to(input int t_end, input logic [31:0] segs, input string tag,
                         input int blo, input int bhi);
    int d;
    logic [3:0] oh;
    while (t < t_end) begin
      tick();
      d  = (t / 4) % 4;
      oh = 4'b0001 << d;
      if ((t % 4) == 0 || (t >= blo && t <= bhi)) begin
        expect_out(4'b1111, 8'hFF, tag);
      end else begin
        expect_out(~oh, segs[8*d +: 8], tag);
      end
    end
  endtask

  localparam logic [31:0] SEGS_12345678 = {8'h92, 8'h82, 8'hF8, 8'h80};
  localparam logic [31:0] SEGS_ABCD     = {8'h88, 8'h83, 8'hC6, 8'hA1};
  localparam logic [31:0] SEGS_LO_8000  = {8'h80, 8'hC0, 8'hC0, 8'hC0};
  localparam logic [31:0] SEGS_HI_F0E1  = {8'h8E, 8'hC0, 8'h86, 8'hF9};
  localparam logic [31:0] SEGS_90       = {8'hC0, 8'hC0, 8'h90, 8'hC0};
  localparam logic [31:0] SEGS_5555     = {8'h92, 8'h92, 8'h92, 8'h92};
  localparam logic [31:0] SEGS_ZERO     = {8'hC0, 8'hC0, 8'hC0, 8'hC0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    data     = 32'h12345678;
    load     = 1'b1;
    half_sel = 1'b0;
    blank    = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held for 3 cycles with load active: display dark throughout.
    repeat (2) begin
      tick();
      expect_out(4'b1111, 8'hFF, "reset");
    end
    tick();
    rst_n = 1'b1;
    t = 0;
    expect_out(4'b1111, 8'hFF, "post_reset_dead");

    // First edge after release captures data.
    scan_to(1, SEGS_12345678, "first_load", -1, -1);
    load = 1'b0;
    scan_to(4, SEGS_12345678, "first_load", -1, -1);

    // Scan of 0000ABCD across several frames.
    data = 32'h0000ABCD;
    load = 1'b1;
    scan_to(5, SEGS_ABCD, "scan_abcd", -1, -1);
    load = 1'b0;
    scan_to(48, SEGS_ABCD, "scan_abcd", -1, -1);

    // Half select toggled mid-slot on digit 0.
    data = 32'hF0E18000;
    load = 1'b1;
    scan_to(49, SEGS_LO_8000, "half_lo", -1, -1);
    load     = 1'b0;
    half_sel = 1'b1;
    scan_to(64, SEGS_HI_F0E1, "half_hi", -1, -1);
    half_sel = 1'b0;

    // Blank for 5 cycles mid-frame; scan position keeps running underneath.
    scan_to(66, SEGS_LO_8000, "pre_blank", -1, -1);
    blank = 1'b1;
    scan_to(71, SEGS_LO_8000, "blank", 67, 71);
    blank = 1'b0;
    scan_to(80, SEGS_LO_8000, "unblank", 67, 71);

    // Load on the wrap edge into digit 1.
    scan_to(83, SEGS_LO_8000, "old_digit0", -1, -1);
    data = 32'h00000090;
    load = 1'b1;
    scan_to(84, SEGS_90, "load_on_wrap", -1, -1);
    load = 1'b0;
    scan_to(96, SEGS_90, "load_on_wrap", -1, -1);

    // Asynchronous reset between edges during digit 2.
    data = 32'h00005555;
    load = 1'b1;
    scan_to(97, SEGS_5555, "pre_async", -1, -1);
    load = 1'b0;
    scan_to(105, SEGS_5555, "pre_async", -1, -1);
    tick();
    #2 rst_n = 1'b0;
    expect_out(4'b1111, 8'hFF, "async_reset");
    tick();
    expect_out(4'b1111, 8'hFF, "async_reset_hold");
    tick();
    rst_n = 1'b1;
    t = 0;
    expect_out(4'b1111, 8'hFF, "async_release_dead");
    scan_to(16, SEGS_ZERO, "cleared_shadow", -1, -1);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
